// File: rtl/sdram_rd_checker.sv
// Read-data checker for SDRAM bring-up.
// Snoops accepted read commands and checks each returned beat against the
// incrementing pattern seed, seed+1, ... produced by the write generator.
// Reports per-burst pass/fail, a saturating error count, a no-data timeout and
// a sticky stray-beat flag.
// Optional feature: define SDRAM_RD_CHK_FIRST_ERR_EN to build first-error
// capture; otherwise o_first_err_idx/o_first_err_data are tied to 0.
module sdram_rd_checker #(
    parameter int unsigned P_DATA_WIDTH = 32,
    parameter int unsigned P_LEN_WIDTH  = 10,
    parameter int unsigned P_SEED       = 65535,
    parameter int unsigned P_TIMEOUT    = 4096
) (
    input  logic                    s_clk,
    input  logic                    s_nrst,
    input  logic [1:0]              i_op_cmd,
    input  logic [P_LEN_WIDTH-1:0]  i_op_len,
    input  logic                    i_op_valid,
    input  logic                    i_op_ready,
    input  logic [P_DATA_WIDTH-1:0] i_rd_data,
    input  logic                    i_rd_valid,
    input  logic                    i_clr,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_pass,
    output logic                    o_timeout,
    output logic [15:0]             o_err_cnt,
    output logic [P_LEN_WIDTH-1:0]  o_first_err_idx,
    output logic [P_DATA_WIDTH-1:0] o_first_err_data,
    output logic                    o_stray
);

    localparam int unsigned CNT_WIDTH = $clog2(P_TIMEOUT + 1);
    localparam logic [P_DATA_WIDTH-1:0] SEED     = P_DATA_WIDTH'(P_SEED);
    localparam logic [CNT_WIDTH-1:0]    IDLE_MAX = CNT_WIDTH'(P_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StReport} state_t;

    state_t                  state;
    logic [P_LEN_WIDTH-1:0]  len;
    logic [P_LEN_WIDTH-1:0]  idx;
    logic [CNT_WIDTH-1:0]    idle_cnt;
    logic [15:0]             err_cnt;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic                    timeout;
    logic                    stray;

    logic                    accept;
    logic                    beat;
    logic                    mismatch;
    logic                    last_beat;
    logic [P_DATA_WIDTH-1:0] expected;
    logic [15:0]             err_cnt_next;

    // Decode of command accept, beat comparison and saturating error update.
    always_comb begin
        accept       = i_op_valid & i_op_ready & (i_op_cmd == 2'd1);
        beat         = (state == StRun) & i_rd_valid;
        expected     = SEED + P_DATA_WIDTH'(idx);
        mismatch     = beat & (i_rd_data != expected);
        last_beat    = beat & (idx == len - P_LEN_WIDTH'(1));
        err_cnt_next = err_cnt;
        if (mismatch && (err_cnt != 16'hFFFF)) begin
            err_cnt_next = err_cnt + 16'd1;
        end
    end

    // Main checker FSM with registered status outputs.
    always_ff @(posedge s_clk or negedge s_nrst) begin
        if (!s_nrst) begin
            state    <= StIdle;
            len      <= '0;
            idx      <= '0;
            idle_cnt <= '0;
            err_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            stray    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (i_clr) begin
                        stray   <= 1'b0;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        err_cnt <= '0;
                    end
                    if (i_rd_valid) begin
                        stray <= 1'b1;
                    end
                    if (accept) begin
                        len      <= i_op_len;
                        idx      <= '0;
                        idle_cnt <= '0;
                        err_cnt  <= '0;
                        timeout  <= 1'b0;
                        if (i_op_len != '0) begin
                            state <= StRun;
                            busy  <= 1'b1;
                            pass  <= 1'b0;
                        end else begin
                            // Zero-length read trivially passes.
                            state <= StReport;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    err_cnt <= err_cnt_next;
                    if (beat) begin
                        idx      <= idx + P_LEN_WIDTH'(1);
                        idle_cnt <= '0;
                        if (last_beat) begin
                            state <= StReport;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt_next == 16'd0);
                        end
                    end else if (idle_cnt == IDLE_MAX) begin
                        state   <= StReport;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_WIDTH'(1);
                    end
                end
                StReport: begin
                    if (i_rd_valid) begin
                        stray <= 1'b1;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign o_busy    = busy;
    assign o_done    = done;
    assign o_pass    = pass;
    assign o_timeout = timeout;
    assign o_err_cnt = err_cnt;
    assign o_stray   = stray;

`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
    logic [P_LEN_WIDTH-1:0]  first_idx;
    logic [P_DATA_WIDTH-1:0] first_data;

    // First mismatch of the burst is the one seen while err_cnt is still 0.
    always_ff @(posedge s_clk or negedge s_nrst) begin
        if (!s_nrst) begin
            first_idx  <= '0;
            first_data <= '0;
        end else if ((state == StIdle) && (accept || i_clr)) begin
            first_idx  <= '0;
            first_data <= '0;
        end else if (mismatch && (err_cnt == 16'd0)) begin
            first_idx  <= idx;
            first_data <= i_rd_data;
        end
    end

    assign o_first_err_idx  = first_idx;
    assign o_first_err_data = first_data;
`else
    assign o_first_err_idx  = '0;
    assign o_first_err_data = '0;
`endif

endmodule

// File: tb/tb_sdram_rd_checker.sv
// Directed self-checking bench for sdram_rd_checker (default parameters).
module tb_sdram_rd_checker;

    logic        clk;
    logic        nrst;
    logic [1:0]  op_cmd;
    logic [9:0]  op_len;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        clr;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_cnt;
    logic [9:0]  first_idx;
    logic [31:0] first_data;
    logic        stray;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_rd_checker dut (
        .s_clk            (clk),
        .s_nrst           (nrst),
        .i_op_cmd         (op_cmd),
        .i_op_len         (op_len),
        .i_op_valid       (op_valid),
        .i_op_ready       (op_ready),
        .i_rd_data        (rd_data),
        .i_rd_valid       (rd_valid),
        .i_clr            (clr),
        .o_busy           (busy),
        .o_done           (done),
        .o_pass           (pass),
        .o_timeout        (timeout),
        .o_err_cnt        (err_cnt),
        .o_first_err_idx  (first_idx),
        .o_first_err_data (first_data),
        .o_stray          (stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] cmd, input int len);
        op_cmd   = cmd;
        op_len   = 10'(len);
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
    endtask

    // Beats first..first+n-1 carry seed+i; indices bad_a/bad_b get bit 0 flipped.
    task automatic send_beats(input int first, input int n, input int gap,
                              input int bad_a, input int bad_b);
        for (int i = first; i < first + n; i++) begin
            if (i != first) repeat (gap) step();
            rd_data = 32'(65535 + i);
            if (i == bad_a || i == bad_b) rd_data = rd_data ^ 32'h1;
            rd_valid = 1'b1;
            step();
            rd_valid = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waited;
        logic [31:0] exp_first_idx;
        logic [31:0] exp_first_data;
`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
        exp_first_idx  = 32'd10;
        exp_first_data = 32'h0001_0008;
`else
        exp_first_idx  = 32'd0;
        exp_first_data = 32'd0;
`endif
        nrst     = 1'b0;
        op_cmd   = 2'd0;
        op_len   = 10'd0;
        op_valid = 1'b0;
        op_ready = 1'b1;
        rd_data  = 32'd0;
        rd_valid = 1'b0;
        clr      = 1'b0;
        repeat (3) step();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_idx", first_idx, 0);
        check("rst_first_data", first_data, 0);
        check("rst_stray", stray, 0);
        nrst = 1'b1;
        step();

        // Clean back-to-back burst.
        send_cmd(2'd1, 512);
        check("clean_busy_rise", busy, 1);
        send_beats(0, 511, 0, -1, -1);
        check("clean_no_early_done", done, 0);
        check("clean_busy_mid", busy, 1);
        send_beats(511, 1, 0, -1, -1);
        check("clean_done", done, 1);
        check("clean_busy_low", busy, 0);
        check("clean_pass", pass, 1);
        check("clean_err_cnt", err_cnt, 0);
        step();
        check("clean_done_pulse", done, 0);
        check("clean_pass_hold", pass, 1);

        // Corrupted beats 10 and 300.
        send_cmd(2'd1, 512);
        check("corr_pass_cleared", pass, 0);
        send_beats(0, 512, 0, 10, 300);
        check("corr_done", done, 1);
        check("corr_err_cnt", err_cnt, 2);
        check("corr_pass", pass, 0);
        check("corr_first_idx", first_idx, exp_first_idx);
        check("corr_first_data", first_data, exp_first_data);
        step();
        check("corr_err_hold", err_cnt, 2);

        // Timeout after 3 of 8 beats.
        send_cmd(2'd1, 8);
        check("to_first_cleared", first_idx, 0);
        send_beats(0, 3, 0, -1, -1);
        waited = 0;
        while (done !== 1'b1 && waited < 5000) begin
            step();
            waited++;
        end
        check("to_latency", waited, 4096);
        check("to_timeout", timeout, 1);
        check("to_pass", pass, 0);
        check("to_err_cnt", err_cnt, 0);
        check("to_busy", busy, 0);
        step();

        // Zero-length read.
        send_cmd(2'd1, 0);
        check("len0_done", done, 1);
        check("len0_pass", pass, 1);
        check("len0_busy", busy, 0);
        check("len0_timeout_cleared", timeout, 0);
        step();

        // Gapped len=4 burst.
        send_cmd(2'd1, 4);
        send_beats(0, 4, 2, -1, -1);
        check("gap_done", done, 1);
        check("gap_pass", pass, 1);
        check("gap_err_cnt", err_cnt, 0);
        step();

        // Stray beat in idle, then clear.
        rd_data  = 32'h1234;
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        check("stray_set", stray, 1);
        check("stray_no_busy", busy, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_stray", stray, 0);
        check("clr_pass", pass, 0);

        // Write accept in idle is ignored.
        send_cmd(2'd2, 4);
        check("wr_ignored_busy", busy, 0);
        step();

        // Write and read accepts during run do not restart the burst.
        send_cmd(2'd1, 16);
        send_beats(0, 4, 0, -1, -1);
        send_cmd(2'd2, 2);
        send_cmd(2'd1, 2);
        check("ign_still_busy", busy, 1);
        send_beats(4, 11, 0, -1, -1);
        check("ign_no_early_done", done, 0);
        send_beats(15, 1, 0, -1, -1);
        check("ign_done", done, 1);
        check("ign_pass", pass, 1);
        check("ign_err_cnt", err_cnt, 0);
        step();

        // Asynchronous reset mid-burst.
        send_cmd(2'd1, 512);
        send_beats(0, 100, 0, 5, -1);
        check("mid_err_before_rst", err_cnt, 1);
        nrst = 1'b0;
        #2;
        check("arst_busy", busy, 0);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_first_idx", first_idx, 0);
        check("arst_pass", pass, 0);
        #1;
        nrst = 1'b1;
        step();
        send_cmd(2'd1, 4);
        check("post_rst_busy", busy, 1);
        send_beats(0, 4, 0, -1, -1);
        check("post_rst_done", done, 1);
        check("post_rst_pass", pass, 1);
        check("post_rst_err_cnt", err_cnt, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
